// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : One-deep valid/ready pipeline register with stall, flush and a
//            bubble counter. Define PIPE_STAGE_SKID_EN for a one-entry skid
//            buffer with a registered in_ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             w_accept;
  logic             w_consume;
  logic             w_out_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_bubble_cnt;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = w_out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_skid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
        S_FULL: begin
          if (w_accept && !w_consume)      w_state_nxt = S_SKID;
          else if (!w_accept && w_consume) w_state_nxt = S_EMPTY;
        end
        S_SKID:  if (w_consume) w_state_nxt = S_FULL;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Ready is a pure register so out_ready never reaches in_ready combinationally;
  // the reset value of 1 lets the first edge after reset accept.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_in_ready <= 1'b1;
    else       r_in_ready <= (w_state_nxt != S_SKID) & ~stall & ~flush;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_data <= BUBBLE;
      r_skid <= BUBBLE;
    end else if (flush) begin
      r_data <= BUBBLE;
      r_skid <= BUBBLE;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) r_data <= in_data;
        S_FULL: begin
          if (w_accept && w_consume) r_data <= in_data;
          else if (w_accept)         r_skid <= in_data;
          else if (w_consume)        r_data <= BUBBLE;
        end
        S_SKID: begin
          if (w_consume) begin
            r_data <= r_skid;
            r_skid <= BUBBLE;
          end
        end
        default: r_data <= BUBBLE;
      endcase
    end
  end

  assign w_out_valid = (r_state != S_EMPTY);
  assign in_ready    = r_in_ready & ~Reset;

`else

  logic r_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
    end else if (w_consume) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end
  end

  assign w_out_valid = r_valid;
  assign in_ready    = ~Reset & ~stall & ~flush & (~r_valid | out_ready);

`endif

  // Counts on the pre-update valid, wrapping freely.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)             r_bubble_cnt <= '0;
    else if (!w_out_valid) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
  end

  assign out_valid  = w_out_valid;
  assign out_data   = r_data;
  assign bubble_cnt = r_bubble_cnt;

endmodule

`default_nettype wire
